// File: rtl/param_updown_counter.sv
// Purpose: prescaled up/down counter with wrap, saturate and one-shot terminal modes.
// Latency: count and tc update one cycle after the tick that causes them; count_oe is combinational.
// Backpressure: none; en stalls prescaler and counting, load_e overrides everything synchronously.
module param_updown_counter #(
  parameter int WIDTH = 8,
  parameter int PW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_e,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [PW-1:0]    presc,
  input  logic             out_e,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_oe,
  output logic             tc,
  output logic             done
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [PW-1:0]    P_ONE   = PW'(1);

  logic [0:0]       state;
  logic [PW-1:0]    p;
  logic             running;
  logic             tick;
  logic             terminal;
  logic             stop;
  logic [WIDTH-1:0] count_nxt;

  // Tick and terminal decode; DONE suppresses ticks so count and tc stay frozen.
  always_comb begin
    running  = (state == ST_RUN);
    tick     = en && running && (p == presc);
    terminal = up ? (count >= limit) : (count == '0);
  end

  // Next count value for a tick: step when not terminal, otherwise apply the mode rule.
  always_comb begin
    count_nxt = count;
    stop      = 1'b0;
    if (!terminal) begin
      count_nxt = up ? (count + CNT_ONE) : (count - CNT_ONE);
    end else begin
      case (mode)
        MODE_SAT:     count_nxt = count;
        MODE_ONESHOT: begin
          count_nxt = count;
          stop      = 1'b1;
        end
        default:      count_nxt = up ? '0 : limit;
      endcase
    end
  end

  // Prescaler: advances only on enabled RUN cycles, restarts on its compare match or on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else if (load_e) begin
      p <= '0;
    end else if (en && running) begin
      p <= (p == presc) ? '0 : (p + P_ONE);
    end
  end

  // Count, terminal pulse and RUN/DONE state; load wins over any tick in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tc    <= 1'b0;
      state <= ST_RUN;
    end else if (load_e) begin
      count <= load_val;
      tc    <= 1'b0;
      state <= ST_RUN;
    end else begin
      tc <= tick && terminal;
      if (tick) begin
        count <= count_nxt;
        if (stop) begin
          state <= ST_DONE;
        end
      end
    end
  end

  assign done     = (state == ST_DONE);
  assign count_oe = {WIDTH{out_e}};

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter/data width (2..32).
REQ-002 SHALL have parameter PW, default 4, prescaler compare width (1..16).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port load_e  input  1  synchronous load strobe.
REQ-006 SHALL have port load_val  input  WIDTH  value loaded into count.
REQ-007 SHALL have port en  input  1  count enable; gates prescaler and counting.
REQ-008 SHALL have port up  input  1  direction: 1 = up, 0 = down.
REQ-009 SHALL have port mode  input  2  00 WRAP, 01 SATURATE, 10 ONESHOT, 11 decoded as WRAP.
REQ-010 SHALL have port limit  input  WIDTH  up-count terminal value (modulus-1).
REQ-011 SHALL have port presc  input  PW  prescale compare; a tick occurs every presc+1 enabled cycles.
REQ-012 SHALL have port out_e  input  1  output drive enable.
REQ-013 SHALL have port count  output  WIDTH  registered counter value, always driven.
REQ-014 SHALL have port count_oe  output  WIDTH  all bits equal out_e, combinational.
REQ-015 SHALL have port tc  output  1  registered one-cycle terminal-event pulse.
REQ-016 SHALL have port done  output  1  high while FSM is in DONE.

Function
REQ-017 SHALL keep PW-bit prescaler p; with en=1, p==presc -> tick asserted that cycle and p<=0, else p<=p+1; with en=0, p holds and no tick.
REQ-018 SHALL treat presc=0 as tick on every enabled cycle.
REQ-019 SHALL define terminal as count>=limit when up=1 and count==0 when up=0.
REQ-020 SHALL, on tick with count not terminal, step count by +1 (up) or -1 (down), modulo 2^WIDTH; result visible the following cycle.
REQ-021 SHALL, on tick at terminal in WRAP: up -> count<=0, down -> count<=limit.
REQ-022 SHALL, on tick at terminal in SATURATE: count holds.
REQ-023 SHALL, on tick at terminal in ONESHOT: count holds and FSM RUN->DONE.
REQ-024 SHALL assert tc for exactly one cycle, the cycle after any tick taken at terminal, in all modes (at most once in ONESHOT).
REQ-025 SHALL implement two-state FSM RUN/DONE; DONE ignores ticks (count, tc frozen, p holds); DONE exits to RUN only on load_e.
REQ-026 SHALL give load_e priority over tick: count<=load_val, p<=0, tc<=0, FSM<=RUN, regardless of en, mode or state.
REQ-027 SHALL apply mode, up, limit, presc changes at the next tick, no internal capture.
REQ-028 SHALL, when limit=0 and up=1, treat every value as terminal (WRAP gives constant 0 with tc per tick).
REQ-029 SHALL, when load_val>limit in up mode, treat the loaded value as terminal at the first tick.

Reset
REQ-030 SHALL, while rst_n=0 (asynchronous), force count=0, p=0, tc=0, FSM=RUN, done=0.
REQ-031 SHALL, if reset asserts mid-count or in DONE, abort with no tc pulse; counting resumes from 0 on the first enabled cycle after release.
REQ-032 SHALL keep count_oe dependent only on out_e, including during reset.

Verification
REQ-033 SHALL verify WRAP up: limit=5, presc=0, en=1 from reset -> count 1,2,3,4,5,0; tc high only the cycle count returns to 0.
REQ-034 SHALL verify WRAP down with prescaler: load 2, presc=2, up=0, limit=9 -> count changes every 3 cycles 2,1,0,9; one tc at 0->9.
REQ-035 SHALL verify SATURATE: limit=3, up=1 -> count stops at 3; tc pulses once per tick while held (every presc+1 cycles).
REQ-036 SHALL verify ONESHOT: limit=4 -> count reaches 4, single tc, done=1 and frozen for 20 cycles; load_e with load_val=1 -> done=0, counting resumes at 2.
REQ-037 SHALL verify load priority and async reset: load_e and tick same cycle -> count=load_val, no tc; rst_n low mid-cycle -> count=0 immediately without a clock edge.
REQ-038 SHALL verify WIDTH=4 wrap: up=1, limit=15 -> 15->0 with tc; out_e toggled -> count_oe toggles 0x0/0xF combinationally.
